cbus_mem_responder: RTL and testbench
=====================================

CBUS_MEM_RESPONDER -- requirements
Module: cbus_mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 4096: memory depth in 32-bit words; power of two.
REQ-002 SHALL have parameter LATENCY, default 2: idle cycles between request capture and first data beat; range 0..15.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port creq, input, cbus_req_t: cache-bus request (valid, is_write, size, addr, strobe, data, len, burst).
REQ-006 SHALL have port cresp, output, cbus_resp_t: cache-bus response (ready, last, data).

Function
REQ-007 SHALL hold MEM_WORDS x 32-bit words; word index = creq.addr[log2(MEM_WORDS)+1:2]; higher address bits and addr[1:0] are ignored.
REQ-008 SHALL implement states IDLE, WAIT, BURST.
REQ-009 IDLE: cresp.ready=0 and cresp.last=0; when creq.valid=1, capture addr index, is_write and len; go to WAIT with wait counter=LATENCY-1, or go directly to BURST when LATENCY=0; clear beat counter.
REQ-010 WAIT: ready=0; decrement the wait counter; go to BURST in the cycle after the counter reaches 0, giving exactly LATENCY wait cycles.
REQ-011 BURST: cresp.ready=1 in every cycle; the beat counter increments by 1 per cycle; the beat index is captured index + beat, modulo MEM_WORDS.
REQ-012 Beat count SHALL be len+1, from the len encoding: MLEN_1=0, MLEN_4=3, MLEN_8=7, MLEN_16=15.
REQ-013 cresp.last SHALL be 1 only when ready=1 and beat == captured len; the next state is then IDLE.
REQ-014 Read beats SHALL drive cresp.data with mem[beat index] combinationally in the same cycle as ready; cresp.data=0 whenever ready=0.
REQ-015 Write beats SHALL update byte k of mem[beat index] from creq.data[8k+7:8k] at the clock edge where ready=1, for each k with creq.strobe[k]=1; strobe=0 leaves the word unchanged.
REQ-016 Writes SHALL ignore creq.size; reads SHALL always return the full word.
REQ-017 Only the INCR burst type is supported; any other burst value SHALL be treated as INCR.
REQ-018 A read beat to the index written in the same cycle SHALL return the old value.
REQ-019 If creq.valid falls during WAIT or BURST (a protocol violation), the block SHALL return to IDLE at the next edge; that cycle SHALL perform no write and keep ready=0.
REQ-020 creq fields other than valid and data/strobe SHALL be ignored after capture.
REQ-021 creq.valid seen in IDLE in the cycle immediately after last SHALL start a new transaction; there is no dead cycle.
REQ-022 Beat index wrap past MEM_WORDS-1 SHALL continue at 0.

Reset
REQ-023 resetn=0 SHALL force IDLE immediately, and force cresp.ready=0, cresp.last=0, cresp.data=0 and all counters to 0.
REQ-024 Memory contents SHALL NOT be cleared by reset.
REQ-025 Reset during BURST SHALL abort the transaction; a write beat on the edge where reset asserts SHALL NOT occur.
REQ-026 After resetn rises, the first transaction SHALL be accepted on the first edge with creq.valid=1.

Verification
REQ-027 LATENCY=2, write MLEN_4 at addr 0x100, data 0x11,0x22,0x33,0x44, strobe 0xF -> ready first in cycle 3 after valid; last on 4th beat; mem[0x40..0x43]=0x11..0x44.
REQ-028 Read MLEN_4 at 0x100 after REQ-027 -> data 0x11,0x22,0x33,0x44 on consecutive ready cycles; last with 0x44; ready/last 0 in the following cycle.
REQ-029 Write 0xAABBCCDD with strobe 0x5 to a word holding 0 -> a following MLEN_1 read returns 0x00BB00DD.
REQ-030 MEM_WORDS=4096, MLEN_16 read at addr 0x3FF8 -> beats return words 4094, 4095, 0, 1, ..., 13.
REQ-031 resetn pulsed low during beat 2 of an MLEN_8 write -> outputs 0 immediately; state IDLE; beats 0-1 written; beats 2-7 unchanged.
REQ-032 LATENCY=0, back-to-back MLEN_1 reads with valid held and addr changed the cycle after last -> ready on the same cycle as each capture edge+1, second data correct, no idle gap.

Source files
------------

// File: rtl/cbus_mem_responder.sv
// Cache-bus memory responder: a word-addressed RAM that answers INCR bursts
// after a fixed number of wait cycles, one beat per clock once ready rises.
package cbus_pkg;

    localparam logic [3:0] MLEN_1  = 4'd0;
    localparam logic [3:0] MLEN_4  = 4'd3;
    localparam logic [3:0] MLEN_8  = 4'd7;
    localparam logic [3:0] MLEN_16 = 4'd15;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [3:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2
    } cbus_mem_state_e;

endpackage

// Handshake: the requester holds creq.valid high for the whole transaction;
// a beat transfers in every cycle where cresp.ready=1, and the beat with
// cresp.last=1 ends it. Dropping valid early aborts without a further write.
module cbus_mem_responder
    import cbus_pkg::*;
#(
    parameter int MEM_WORDS = 4096,
    parameter int LATENCY   = 2
) (
    input  logic            clk,
    input  logic            resetn,
    input  cbus_req_t       creq,
    output cbus_resp_t      cresp,
    output cbus_mem_state_e dbg_state
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [3:0] WAIT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    logic [31:0] mem [MEM_WORDS];

    cbus_mem_state_e state, state_nxt;
    logic [3:0]      wait_cnt;
    logic [3:0]      beat;
    logic [3:0]      cap_len;
    logic            cap_write;
    logic [AW-1:0]   cap_idx;
    logic [AW-1:0]   beat_idx;
    logic            beat_on;
    logic            beat_last;
    logic            wr_en;
    logic            unused_bits;

    // Unsigned add of a narrower beat count wraps naturally at MEM_WORDS.
    assign beat_idx    = cap_idx + AW'(beat);
    assign beat_on     = (state == ST_BURST) && creq.valid;
    assign beat_last   = (beat == cap_len);
    assign dbg_state   = state;
    assign unused_bits = ^{creq.size, creq.burst, creq.addr[31:AW+2], creq.addr[1:0]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            wait_cnt  <= 4'd0;
            beat      <= 4'd0;
            cap_len   <= 4'd0;
            cap_write <= 1'b0;
            cap_idx   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (creq.valid) begin
                        cap_idx   <= creq.addr[AW+1:2];
                        cap_write <= creq.is_write;
                        cap_len   <= creq.len;
                        wait_cnt  <= WAIT_INIT;
                        beat      <= 4'd0;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
                end
                ST_BURST: begin
                    if (creq.valid) beat <= beat + 4'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (creq.valid) state_nxt = (LATENCY == 0) ? ST_BURST : ST_WAIT;
            end
            ST_WAIT: begin
                if (!creq.valid)          state_nxt = ST_IDLE;
                else if (wait_cnt == 4'd0) state_nxt = ST_BURST;
            end
            ST_BURST: begin
                if (!creq.valid || beat_last) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cresp = '0;
        wr_en = 1'b0;
        if (beat_on) begin
            cresp.ready = 1'b1;
            cresp.last  = beat_last;
            wr_en       = cap_write;
            if (!cap_write) cresp.data = mem[beat_idx];
        end
    end

    // No reset on the array: contents survive resetn.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (creq.strobe[k]) mem[beat_idx][8*k +: 8] <= creq.data[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_cbus_mem_responder.sv
// Directed bench for cbus_mem_responder: one LATENCY=2 instance and one
// LATENCY=0 instance share a request bus, selected by sel0.
module tb_cbus_mem_responder;
    import cbus_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic sel0 = 1'b0;
    always #5 clk = ~clk;

    cbus_req_t       creq, creq_a, creq_b;
    cbus_resp_t      cresp, cresp_a, cresp_b;
    cbus_mem_state_e st, st_a, st_b;

    always_comb begin
        creq_a       = creq;
        creq_b       = creq;
        creq_a.valid = creq.valid & ~sel0;
        creq_b.valid = creq.valid & sel0;
        cresp        = sel0 ? cresp_b : cresp_a;
        st           = sel0 ? st_b : st_a;
    end

    cbus_mem_responder #(.MEM_WORDS(4096), .LATENCY(2)) u_dut_a (
        .clk(clk), .resetn(resetn), .creq(creq_a), .cresp(cresp_a), .dbg_state(st_a)
    );

    cbus_mem_responder #(.MEM_WORDS(4096), .LATENCY(0)) u_dut_b (
        .clk(clk), .resetn(resetn), .creq(creq_b), .cresp(cresp_b), .dbg_state(st_b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] wr_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Runs one transaction; write data comes from wr_q, read expectations from exp_q.
    // abort_beat >= 0 pulses resetn low during that beat instead of finishing.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                           input logic [3:0] strb, input int first_cyc, input int abort_beat);
        int  beat;
        int  cyc;
        bit  done;
        bit  adv;
        beat = 0;
        cyc  = 0;
        done = 0;
        @(posedge clk); #1;
        creq          = '0;
        creq.valid    = 1'b1;
        creq.is_write = wr;
        creq.addr     = addr;
        creq.len      = len;
        creq.strobe   = strb;
        creq.size     = 3'd2;
        creq.burst    = 2'd3;
        if (wr && wr_q.size() > 0) creq.data = wr_q.pop_front();
        while (!done && cyc < 64) begin
            adv = 0;
            @(negedge clk);
            if (cresp.ready) begin
                adv = 1;
                if (beat == 0) check("first_ready_cycle", 32'(cyc), 32'(first_cyc));
                check("last_flag", {31'd0, cresp.last}, {31'd0, beat == int'(len)});
                if (!wr && exp_q.size() > 0) check("read_data", cresp.data, exp_q.pop_front());
                if (beat == abort_beat) begin
                    resetn = 1'b0;
                    #1;
                    check("abort_ready", {31'd0, cresp.ready}, 32'd0);
                    check("abort_last", {31'd0, cresp.last}, 32'd0);
                    check("abort_data", cresp.data, 32'd0);
                    check("abort_state", {30'd0, st}, {30'd0, ST_IDLE});
                    creq.valid = 1'b0;
                    done = 1;
                end else if (cresp.last) begin
                    done = 1;
                end
                beat++;
            end
            cyc++;
            if (!done) begin
                @(posedge clk); #1;
                if (adv && wr && wr_q.size() > 0) creq.data = wr_q.pop_front();
            end
        end
        check("txn_done", {31'd0, done}, 32'd1);
        @(posedge clk); #1;
        if (abort_beat >= 0) resetn = 1'b1;
        else creq.valid = 1'b0;
    endtask

    initial begin
        creq = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", {31'd0, cresp.ready}, 32'd0);
        check("reset_last", {31'd0, cresp.last}, 32'd0);
        check("reset_data", cresp.data, 32'd0);
        check("reset_state", {30'd0, st}, {30'd0, ST_IDLE});
        @(posedge clk); #1;
        resetn = 1'b1;

        // MLEN_4 write at 0x100, then read back; ready/last drop after last.
        wr_q = '{32'h11, 32'h22, 32'h33, 32'h44};
        run_txn(1'b1, 32'h100, MLEN_4, 4'hF, 3, -1);
        exp_q = '{32'h11, 32'h22, 32'h33, 32'h44};
        run_txn(1'b0, 32'h100, MLEN_4, 4'h0, 3, -1);
        @(negedge clk);
        check("post_last_ready", {31'd0, cresp.ready}, 32'd0);
        check("post_last_last", {31'd0, cresp.last}, 32'd0);

        // High address bits and addr[1:0] ignored: 0xFFFF0103 -> word 0x40.
        exp_q = '{32'h11};
        run_txn(1'b0, 32'hFFFF_0103, MLEN_1, 4'h0, 3, -1);

        // Byte strobes; strobe 0 leaves the word alone.
        wr_q = '{32'h0};
        run_txn(1'b1, 32'h200, MLEN_1, 4'hF, 3, -1);
        wr_q = '{32'hAABB_CCDD};
        run_txn(1'b1, 32'h200, MLEN_1, 4'h5, 3, -1);
        wr_q = '{32'hFFFF_FFFF};
        run_txn(1'b1, 32'h200, MLEN_1, 4'h0, 3, -1);
        exp_q = '{32'h00BB_00DD};
        run_txn(1'b0, 32'h200, MLEN_1, 4'h0, 3, -1);

        // Valid dropped mid-burst: no write in that cycle, back to IDLE.
        @(posedge clk); #1;
        creq = '0;
        creq.valid = 1'b1; creq.is_write = 1'b1; creq.addr = 32'h100;
        creq.len = MLEN_4; creq.strobe = 4'hF; creq.data = 32'hCAFE_0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("drop_beat0_ready", {31'd0, cresp.ready}, 32'd1);
        @(posedge clk); #1;
        creq.valid = 1'b0;
        creq.data  = 32'hBAD0_BAD0;
        @(negedge clk);
        check("drop_ready", {31'd0, cresp.ready}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("drop_state", {30'd0, st}, {30'd0, ST_IDLE});
        exp_q = '{32'hCAFE_0000, 32'h22, 32'h33, 32'h44};
        run_txn(1'b0, 32'h100, MLEN_4, 4'h0, 3, -1);

        // MLEN_16 at 0x3FF8 wraps from word 4095 to 0.
        for (int i = 0; i < 16; i++) wr_q.push_back(32'h1000 + i);
        run_txn(1'b1, 32'h3FF8, MLEN_16, 4'hF, 3, -1);
        for (int i = 0; i < 16; i++) exp_q.push_back(32'h1000 + i);
        run_txn(1'b0, 32'h3FF8, MLEN_16, 4'h0, 3, -1);
        exp_q = '{32'h1002};
        run_txn(1'b0, 32'h0, MLEN_1, 4'h0, 3, -1);
        exp_q = '{32'h100F};
        run_txn(1'b0, 32'h34, MLEN_1, 4'h0, 3, -1);

        // Reset during beat 2 of an MLEN_8 write: beats 0-1 land, 2-7 keep old data.
        for (int i = 0; i < 8; i++) wr_q.push_back(32'h5500 + i);
        run_txn(1'b1, 32'h400, MLEN_8, 4'hF, 3, -1);
        wr_q = '{};
        for (int i = 0; i < 8; i++) wr_q.push_back(32'hA000 + i);
        run_txn(1'b1, 32'h400, MLEN_8, 4'hF, 3, 2);
        wr_q = '{};
        exp_q = '{32'hA000, 32'hA001, 32'h5502, 32'h5503, 32'h5504, 32'h5505, 32'h5506, 32'h5507};
        run_txn(1'b0, 32'h400, MLEN_8, 4'h0, 3, -1);

        // LATENCY=0 instance: back-to-back MLEN_1 reads with valid held.
        sel0 = 1'b1;
        wr_q = '{32'h7000, 32'h7001, 32'h7002, 32'h7003};
        run_txn(1'b1, 32'h100, MLEN_4, 4'hF, 1, -1);
        @(posedge clk); #1;
        creq = '0;
        creq.valid = 1'b1; creq.addr = 32'h100; creq.len = MLEN_1;
        @(negedge clk);
        check("b2b_idle0_ready", {31'd0, cresp.ready}, 32'd0);
        @(negedge clk);
        check("b2b_first_ready", {31'd0, cresp.ready}, 32'd1);
        check("b2b_first_last", {31'd0, cresp.last}, 32'd1);
        check("b2b_first_data", cresp.data, 32'h7000);
        @(posedge clk); #1;
        creq.addr = 32'h104;
        @(negedge clk);
        check("b2b_gap_state", {30'd0, st}, {30'd0, ST_IDLE});
        @(negedge clk);
        check("b2b_second_ready", {31'd0, cresp.ready}, 32'd1);
        check("b2b_second_last", {31'd0, cresp.last}, 32'd1);
        check("b2b_second_data", cresp.data, 32'h7001);
        @(posedge clk); #1;
        creq.valid = 1'b0;
        @(negedge clk);
        check("b2b_end_ready", {31'd0, cresp.ready}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
